// File: rtl/adder_pipelined_nbit.sv
// rtl/adder_pipelined_nbit.sv - pipelined ripple-carry adder, one slice per stage, valid/ready handshakes
module adder_pipelined_nbit #(
  parameter int BIT_WIDTH = 16,
  parameter int STAGES    = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam int SW = BIT_WIDTH / STAGES;

  // Stage i (0-based) holds: valid bit, sum slices 0..i, operands (upper slices still needed),
  // and the carry out of slice i.
  logic [STAGES-1:0]    r_valid;
  logic [STAGES-1:0]    r_carry;
  logic [BIT_WIDTH-1:0] r_sum [STAGES];
  logic [BIT_WIDTH-1:0] r_a   [STAGES];
  logic [BIT_WIDTH-1:0] r_b   [STAGES];

  // Upstream view of each stage: index 0 is the input port, index i is stage i-1.
  logic [STAGES-1:0]    w_up_valid;
  logic [STAGES-1:0]    w_up_carry;
  logic [BIT_WIDTH-1:0] w_up_sum [STAGES];
  logic [BIT_WIDTH-1:0] w_up_a   [STAGES];
  logic [BIT_WIDTH-1:0] w_up_b   [STAGES];

  // Handshake chain: w_free[i] means stage i can take new contents this cycle.
  // w_free[STAGES] stands for the downstream consumer.
  logic [STAGES:0]      w_free;
  logic [STAGES-1:0]    w_leave;

  // Per-stage next contents.
  logic [SW:0]          w_slice    [STAGES];
  logic [BIT_WIDTH-1:0] w_sum_nxt  [STAGES];
  logic [STAGES-1:0]    w_carry_nxt;

  // Select each stage's source: the ports for the first stage, the previous stage otherwise.
  always_comb begin
    w_up_valid    = '0;
    w_up_carry    = '0;
    w_up_valid[0] = in_valid;
    w_up_carry[0] = carry_in;
    w_up_sum[0]   = '0;
    w_up_a[0]     = a;
    w_up_b[0]     = b;
    for (int i = 1; i < STAGES; i++) begin
      w_up_valid[i] = r_valid[i-1];
      w_up_carry[i] = r_carry[i-1];
      w_up_sum[i]   = r_sum[i-1];
      w_up_a[i]     = r_a[i-1];
      w_up_b[i]     = r_b[i-1];
    end
  end

  // Bubble-collapsing advance chain, evaluated from the output back towards the input so a
  // stage frees up in the same cycle its successor drains.
  always_comb begin
    w_free         = '0;
    w_leave        = '0;
    w_free[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_leave[i] = r_valid[i] & w_free[i+1];
      w_free[i]  = ~r_valid[i] | w_leave[i];
    end
  end

  // Slice adder for each stage: add slice i of the operands with the incoming carry and
  // merge the result into the partial sum carried down the pipe.
  always_comb begin
    w_carry_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_slice[i] = {1'b0, w_up_a[i][i*SW +: SW]}
                 + {1'b0, w_up_b[i][i*SW +: SW]}
                 + {{SW{1'b0}}, w_up_carry[i]};
      w_sum_nxt[i]             = w_up_sum[i];
      w_sum_nxt[i][i*SW +: SW] = w_slice[i][SW-1:0];
      w_carry_nxt[i]           = w_slice[i][SW];
    end
  end

  // Pipeline registers: a free stage takes whatever its upstream offers (possibly a bubble);
  // a stalled stage keeps everything.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid <= '0;
      r_carry <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_sum[i] <= '0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_free[i]) begin
          r_valid[i] <= w_up_valid[i];
          if (w_up_valid[i]) begin
            r_sum[i]   <= w_sum_nxt[i];
            r_a[i]     <= w_up_a[i];
            r_b[i]     <= w_up_b[i];
            r_carry[i] <= w_carry_nxt[i];
          end
        end
      end
    end
  end

  // Outputs come straight from the last stage's registers; in_ready is the head of the chain.
  always_comb begin
    in_ready  = w_free[0];
    out_valid = r_valid[STAGES-1];
    sum       = r_sum[STAGES-1];
    overflow  = r_carry[STAGES-1];
  end

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// tb/tb_adder_pipelined_nbit.sv - directed self-checking bench for adder_pipelined_nbit
module tb_adder_pipelined_nbit;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-stage instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, ovf;
  logic [15:0] a, b, sum;
  // 8-bit, 1-stage instance
  logic        s1_in_valid, s1_in_ready, s1_cin, s1_out_valid, s1_out_ready, s1_ovf;
  logic [7:0]  s1_a, s1_b, s1_sum;
  // 8-bit, 8-stage instance
  logic        s8_in_valid, s8_in_ready, s8_cin, s8_out_valid, s8_out_ready, s8_ovf;
  logic [7:0]  s8_a, s8_b, s8_sum;

  int n_pass = 0;
  int n_total = 0;

  adder_pipelined_nbit #(.BIT_WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .carry_in(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(ovf));

  adder_pipelined_nbit #(.BIT_WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .n_rst(n_rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .a(s1_a), .b(s1_b),
    .carry_in(s1_cin), .out_valid(s1_out_valid), .out_ready(s1_out_ready), .sum(s1_sum), .overflow(s1_ovf));

  adder_pipelined_nbit #(.BIT_WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .n_rst(n_rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready), .a(s8_a), .b(s8_b),
    .carry_in(s8_cin), .out_valid(s8_out_valid), .out_ready(s8_out_ready), .sum(s8_sum), .overflow(s8_ovf));

  // Single add on the 16/4 instance; returns edges until out_valid (20 means never seen).
  task automatic add16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       output int lat, output logic [15:0] s, output logic o);
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum; o = ovf;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", sum); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_overflow got %b want 0", ovf); else n_pass++;
    n_total++; if (s8_out_valid !== 1'b0) $display("FAIL reset_s8_out_valid got %b want 0", s8_out_valid); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (s1_in_ready !== 1'b1) $display("FAIL reset_s1_in_ready got %b want 1", s1_in_ready); else n_pass++;
    n_total++; if (s8_in_ready !== 1'b1) $display("FAIL reset_s8_in_ready got %b want 1", s8_in_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] s; logic o;
    add16(16'h00FF, 16'h0001, 1'b0, lat, s, o);
    n_total++; if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat); else n_pass++;
    n_total++; if (s !== 16'h0100) $display("FAIL basic_sum got %h want 0100", s); else n_pass++;
    n_total++; if (o !== 1'b0) $display("FAIL basic_overflow got %b want 0", o); else n_pass++;
  endtask

  task automatic test_carry_ripple();
    int lat; logic [15:0] s; logic o;
    add16(16'hFFFF, 16'h0000, 1'b1, lat, s, o);
    n_total++; if (s !== 16'h0000) $display("FAIL ripple1_sum got %h want 0000", s); else n_pass++;
    n_total++; if (o !== 1'b1) $display("FAIL ripple1_overflow got %b want 1", o); else n_pass++;
    add16(16'h8000, 16'h8000, 1'b0, lat, s, o);
    n_total++; if (s !== 16'h0000) $display("FAIL ripple2_sum got %h want 0000", s); else n_pass++;
    n_total++; if (o !== 1'b1) $display("FAIL ripple2_overflow got %b want 1", o); else n_pass++;
    add16(16'h0FFF, 16'h0001, 1'b0, lat, s, o);
    n_total++; if (s !== 16'h1000 || o !== 1'b0) $display("FAIL ripple3 got %h/%b want 1000/0", s, o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    int first_edge = -1;
    int last_edge = -1;
    logic [15:0] got [8];
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      a = 16'(c); b = 16'h1000; cin = 1'b0;
      #2;
      if (c < 8) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b want 1", c, in_ready); else n_pass++;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (first_edge < 0) first_edge = c + 1;
        last_edge = c + 1;
        if (n_out < 8) got[n_out] = sum;
        n_out++;
      end
    end
    in_valid = 1'b0;
    n_total++; if (n_out !== 8) $display("FAIL stream_count got %0d want 8", n_out); else n_pass++;
    n_total++; if (first_edge !== 4) $display("FAIL stream_first_cycle got %0d want 4", first_edge); else n_pass++;
    n_total++; if (last_edge !== 11) $display("FAIL stream_last_cycle got %0d want 11", last_edge); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (i < n_out && got[i] === 16'h1000 + 16'(i)) n_pass++;
      else $display("FAIL stream_sum[%0d] got %h want %h", i, (i < n_out) ? got[i] : 16'hxxxx, 16'h1000 + 16'(i));
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rx = 0;
    logic [15:0] hold = '0;
    logic [15:0] exp_sum;
    for (int k = 0; k < 30; k++) begin
      out_ready = !(k >= 6 && k <= 11);
      in_valid = (sent < 14);
      a = 16'h2000 + 16'(sent); b = 16'h0100; cin = sent[0];
      #2;
      if (out_valid && out_ready) begin
        exp_sum = 16'h2100 + 16'(rx) + 16'(rx & 1);
        n_total++;
        if (rx < 14 && sum === exp_sum && ovf === 1'b0) n_pass++;
        else $display("FAIL bp_result[%0d] got %h/%b want %h/0", rx, sum, ovf, exp_sum);
        rx++;
      end
      if (k >= 6 && k <= 11) begin
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready[%0d] got %b want 0", k, in_ready); else n_pass++;
        if (k == 6) hold = sum;
        else begin
          n_total++;
          if (sum === hold && out_valid === 1'b1) n_pass++;
          else $display("FAIL bp_hold[%0d] got %h/%b want %h/1", k, sum, out_valid, hold);
        end
      end
      if (k == 12) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready); else n_pass++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_total++; if (rx !== 14) $display("FAIL bp_total got %0d want 14", rx); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    int lat; logic [15:0] s; logic o;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h0111 * 16'(i + 1); b = 16'h0002; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (sum !== 16'h0000) $display("FAIL midrst_sum got %h want 0000", sum); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL midrst_overflow got %b want 0", ovf); else n_pass++;
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_total++; if (stale !== 0) $display("FAIL midrst_stale got %0d want 0", stale); else n_pass++;
    add16(16'h1234, 16'h4321, 1'b0, lat, s, o);
    n_total++; if (lat !== 4) $display("FAIL midrst_latency got %0d want 4", lat); else n_pass++;
    n_total++; if (s !== 16'h5555 || o !== 1'b0) $display("FAIL midrst_sum_after got %h/%b want 5555/0", s, o); else n_pass++;
  endtask

  task automatic test_param_sweep();
    int lat1 = 0;
    int lat8 = 0;
    logic [7:0] got1 = '0;
    logic [7:0] got8 = '0;
    logic o1 = 1'b0;
    logic o8 = 1'b0;
    s1_a = 8'hFF; s1_b = 8'h01; s1_cin = 1'b0; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
    s8_a = 8'hFF; s8_b = 8'h01; s8_cin = 1'b0; s8_in_valid = 1'b1; s8_out_ready = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      s1_in_valid = 1'b0;
      s8_in_valid = 1'b0;
      if (s1_out_valid && lat1 == 0) begin lat1 = n; got1 = s1_sum; o1 = s1_ovf; end
      if (s8_out_valid && lat8 == 0) begin lat8 = n; got8 = s8_sum; o8 = s8_ovf; end
    end
    n_total++; if (lat1 !== 1) $display("FAIL s1_latency got %0d want 1", lat1); else n_pass++;
    n_total++; if (got1 !== 8'h00 || o1 !== 1'b1) $display("FAIL s1_result got %h/%b want 00/1", got1, o1); else n_pass++;
    n_total++; if (lat8 !== 8) $display("FAIL s8_latency got %0d want 8", lat8); else n_pass++;
    n_total++; if (got8 !== 8'h00 || o8 !== 1'b1) $display("FAIL s8_result got %h/%b want 00/1", got8, o8); else n_pass++;
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    s1_in_valid = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_out_ready = 1'b1;
    s8_in_valid = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adder_pipelined_nbit.md
Name: adder_pipelined_nbit

Overview:
- Parametrised, pipelined ripple-carry adder. It is the sequential successor to the team's combinational n-bit adder and its 8-bit wrapper.
- The operand width is split into STAGES equal slices. One slice is added per pipeline stage, and the carry is registered between stages.
- Valid/ready handshakes on input and output let it sit between streaming datapath blocks.
- Full throughput is one add per cycle, with bubble-collapsing backpressure.

Parameters:
- BIT_WIDTH, 16: operand and sum width. Must be ≥1.
- STAGES, 4: number of pipeline stages. Must be ≥1 and must divide BIT_WIDTH. Slice width is SW = BIT_WIDTH/STAGES.

Ports:
- clk  in  1: rising-edge clock.
- n_rst  in  1: asynchronous, active-low reset.
- in_valid  in  1: input operands are valid this cycle.
- in_ready  out  1: pipeline can accept an input this cycle.
- a  in  BIT_WIDTH: operand A, unsigned.
- b  in  BIT_WIDTH: operand B, unsigned.
- carry_in  in  1: carry into bit 0.
- out_valid  out  1: sum and overflow are valid.
- out_ready  in  1: downstream accepts the result this cycle.
- sum  out  BIT_WIDTH: a + b + carry_in, modulo 2^BIT_WIDTH.
- overflow  out  1: carry out of the MSB. Same meaning as in the combinational n-bit adder.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (n_rst).
- Pipeline registers: stage k, for k = 1..STAGES, holds:
  - a valid bit;
  - sum slices 0..k-1 already computed;
  - the remaining operand slices k..STAGES-1 of a and b;
  - the carry out of slice k-1.
- Stage 1 datapath: on accept, slice 0 = a[SW-1:0] + b[SW-1:0] + carry_in, and the result is registered into stage 1.
- Stage k+1 datapath: slice k is added using the stage-k carry.
- Output mapping: stage STAGES drives sum, overflow and out_valid directly from registers. There is no combinational path from a, b or carry_in to any output.
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid rising, provided there is no backpressure.
- Throughput: one result per cycle while out_ready stays high.
- Advance rule (bubble collapse):
  - Stage STAGES advances when out_ready is high or the stage is empty.
  - Stage k advances when it is valid and stage k+1 is empty or advancing.
  - in_ready = stage 1 empty or stage 1 advancing. This is combinational from out_ready through the valid chain.
- Handshake rules:
  - A transfer occurs only when valid and ready are both high at the rising edge.
  - While out_valid is high and out_ready is low, sum and overflow hold stable.
  - A stalled stage holds all of its contents.
  - in_valid may drop at any time without effect. The block does not capture inputs unless in_ready is high.
- Pipeline full: when out_ready is low and all STAGES stages are valid, in_ready = 0. When out_ready returns high, in_ready rises in the same cycle and accepting proceeds with no lost or duplicated results.
- Bubbles: an empty stage accepts from the stage before it even while downstream is stalled.
- Simultaneous events: accept and output in the same cycle are allowed when full and out_ready = 1, giving a steady-state full pipe.
- Arithmetic: unsigned. sum = (a + b + carry_in) mod 2^BIT_WIDTH, and overflow = bit BIT_WIDTH of the full sum. The carry must propagate across all slice boundaries, e.g. all-ones + 0 + 1.
- STAGES = 1: degenerates to a single registered adder with latency 1 and the same handshakes.
- Reset values, applied immediately on n_rst low:
  - all stage valid bits = 0;
  - out_valid = 0;
  - sum = 0;
  - overflow = 0;
  - in_ready = 1 once n_rst is high.
- Reset mid-operation: in-flight results are discarded and none are emitted after reset release.

Test Plan:
- Basic add (BIT_WIDTH=16, STAGES=4): a=0x00FF, b=0x0001, carry_in=0 -> 4 cycles later out_valid=1, sum=0x0100, overflow=0.
- Full carry ripple: a=0xFFFF, b=0x0000, carry_in=1 -> sum=0x0000, overflow=1. Also a=0x8000, b=0x8000, carry_in=0 -> sum=0x0000, overflow=1.
- Streaming: 8 back-to-back inputs (a=i, b=0x1000, i=0..7) with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, sum = 0x1000+i in order.
- Backpressure:
  - Stream continuously, then drop out_ready for 6 cycles -> in_ready=0 once 4 results are buffered, and sum holds stable.
  - Raise out_ready -> all results emerge in order with no loss or duplication.
- Reset mid-flight: assert n_rst low with 3 results in flight -> out_valid=0, sum=0, overflow=0 immediately. After release, no stale results appear, and a new add of 0x1234+0x4321 yields 0x5555 after 4 cycles.
- Parameter sweep: BIT_WIDTH=8, STAGES=1 and BIT_WIDTH=8, STAGES=8 with 0xFF+0x01+0 -> sum=0x00, overflow=1 at latencies 1 and 8 respectively.
